// File: rtl/stripes_serial_divider_if.sv
// Operand/result bundle for the bit-serial divider: en/valid request side in, busy/ready result side out.
// The divider sits on the slave modport; the requester drives through master.
interface stripes_serial_divider_if #(
  parameter int MAX_PRECISION = 16,
  parameter int PREC_W        = 6
);
  logic                     en;
  logic [PREC_W-1:0]        precision;
  logic [MAX_PRECISION-1:0] jia;
  logic [MAX_PRECISION-1:0] yi;
  logic                     valid;
  logic                     busy;
  logic                     ready;
  logic [MAX_PRECISION-1:0] quot;
  logic [MAX_PRECISION-1:0] rem;
  logic                     div_zero;
  logic                     ovf;

  modport master (
    output en, precision, jia, yi, valid,
    input  busy, ready, quot, rem, div_zero, ovf
  );

  modport slave (
    input  en, precision, jia, yi, valid,
    output busy, ready, quot, rem, div_zero, ovf
  );
endinterface

// File: rtl/stripes_serial_divider.sv
// Bit-serial signed restoring divider, one quotient bit per enabled clock, single issue.
// Ready pulses N+2 enabled clocks after accept (2 on divide-by-zero); valid is ignored until then.
module stripes_serial_divider #(
  parameter int MAX_PRECISION = 16,
  parameter int PREC_W        = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stripes_serial_divider_if.slave  div_io
);
  localparam int MP = MAX_PRECISION;
  localparam int CW = $clog2(MP + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [MP-1:0] hi_mask(input logic [CW-1:0] n);
    return {MP{1'b1}} << n;
  endfunction

  function automatic logic sign_at(input logic [MP-1:0] x, input logic [CW-1:0] n);
    logic [MP-1:0] top;
    top = {{(MP-1){1'b0}}, 1'b1} << (n - CW'(1));
    return |(x & top);
  endfunction

  function automatic logic [MP-1:0] sext(input logic [MP-1:0] x, input logic [CW-1:0] n);
    return sign_at(x, n) ? (x | hi_mask(n)) : (x & ~hi_mask(n));
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MP-1:0] dvd_q, dvd_d;
  logic [MP-1:0] dvs_q, dvs_d;
  logic [MP-1:0] acc_q, acc_d;
  logic [MP-1:0] qacc_q, qacc_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [MP-1:0] quot_q, quot_d;
  logic [MP-1:0] rem_q, rem_d;
  logic          div_zero_q, div_zero_d;
  logic          ovf_q, ovf_d;

  logic [CW-1:0] n_eff;
  logic [MP-1:0] jia_s, yi_s, jia_mag, yi_mag;
  logic          jia_neg, yi_neg, yi_zero;
  logic [MP:0]   shifted;
  logic          fits;
  logic [MP-1:0] q_sgn, r_sgn;

  always_comb begin
    n_eff   = (div_io.precision == '0 || div_io.precision > PREC_W'(MP)) ? CW'(MP)
                                                                         : CW'(div_io.precision);
    jia_s   = sext(div_io.jia, n_eff);
    yi_s    = sext(div_io.yi, n_eff);
    jia_neg = sign_at(div_io.jia, n_eff);
    yi_neg  = sign_at(div_io.yi, n_eff);
    // Unsigned magnitudes: the most-negative value maps to 2^(N-1), which still fits.
    jia_mag = jia_neg ? -jia_s : jia_s;
    yi_mag  = yi_neg ? -yi_s : yi_s;
    yi_zero = (yi_s == '0);
    shifted = {acc_q, dvd_q[MP-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    q_sgn   = qneg_q ? -qacc_q : qacc_q;
    r_sgn   = rneg_q ? -acc_q : acc_q;

    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    acc_d      = acc_q;
    qacc_d     = qacc_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    ovf_pend_d = ovf_pend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (div_io.valid) begin
          n_d        = n_eff;
          qneg_d     = jia_neg ^ yi_neg;
          rneg_d     = jia_neg;
          dvs_d      = yi_mag;
          dvd_d      = jia_mag << (CW'(MP) - n_eff);
          qacc_d     = '0;
          dz_d       = yi_zero;
          ovf_pend_d = (jia_s == hi_mask(n_eff - CW'(1))) && (yi_s == '1);
          // Divide-by-zero skips the shift steps; acc carries |dividend| into the remainder.
          acc_d      = yi_zero ? jia_mag : '0;
          cnt_d      = yi_zero ? '0 : n_eff;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          acc_d  = fits ? MP'(shifted - {1'b0, dvs_q}) : shifted[MP-1:0];
          qacc_d = {qacc_q[MP-2:0], fits};
          dvd_d  = dvd_q << 1;
          cnt_d  = cnt_q - CW'(1);
        end else begin
          quot_d     = dz_q ? '1 : sext(q_sgn, n_q);
          rem_d      = sext(r_sgn, n_q);
          div_zero_d = dz_q;
          ovf_d      = ovf_pend_q;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      qacc_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (div_io.en) begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      acc_q      <= acc_d;
      qacc_q     <= qacc_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      ovf_pend_q <= ovf_pend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign div_io.busy     = (state_q != IDLE);
  assign div_io.ready    = (state_q == DONE);
  assign div_io.quot     = quot_q;
  assign div_io.rem      = rem_q;
  assign div_io.div_zero = div_zero_q;
  assign div_io.ovf      = ovf_q;
endmodule

// File: tb/tb_stripes_serial_divider.sv
// Randomized bench for the serial divider, scored against an integer-arithmetic reference.
module tb_stripes_serial_divider;
  logic clk;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;

  stripes_serial_divider_if #(.MAX_PRECISION(16), .PREC_W(6)) dif ();

  stripes_serial_divider #(.MAX_PRECISION(16), .PREC_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_io (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer division truncating toward zero, remainder follows dividend.
  function automatic void ref_div(input int prec, input logic [15:0] a, input logic [15:0] b,
                                  output int n, output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
    longint sa, sb, qq, rr, m;
    n  = (prec == 0 || prec > 16) ? 16 : prec;
    m  = longint'(1) << n;
    sa = longint'(a) % m;
    sb = longint'(b) % m;
    if (sa >= m / 2) sa = sa - m;
    if (sb >= m / 2) sb = sb - m;
    dz = (sb == 0);
    ov = (sa == -(m / 2)) && (sb == -1);
    if (dz) begin
      qq = -1;
      rr = sa;
    end else if (ov) begin
      qq = sa;
      rr = 0;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
    end
    q = qq[15:0];
    r = rr[15:0];
  endfunction

  task automatic do_op(input int prec, input logic [15:0] a, input logic [15:0] b,
                       input int stall, input bit scramble);
    int          n, k, lat;
    logic [15:0] eq, er, q_hold;
    logic        edz, eov;
    ref_div(prec, a, b, n, eq, er, edz, eov);
    if (edz || n < 3) stall = 0;
    lat = (edz ? 1 : n + 1) + stall;

    @(negedge clk);
    dif.en        = 1'b1;
    dif.valid     = 1'b1;
    dif.precision = 6'(prec);
    dif.jia       = a;
    dif.yi        = b;
    @(posedge clk);
    @(negedge clk);
    dif.valid = 1'b0;
    check("busy_after_accept", 32'(dif.busy), 32'd1);

    k = 0;
    while (k < 200) begin
      if (scramble) begin
        dif.valid     = 1'($urandom);
        dif.jia       = 16'($urandom);
        dif.yi        = 16'($urandom);
        dif.precision = 6'($urandom);
      end
      if (stall > 0 && k == 2) begin
        q_hold = dif.quot;
        dif.en = 1'b0;
        repeat (stall) begin
          @(posedge clk);
          k++;
          @(negedge clk);
          check("stall_ready_low", 32'(dif.ready), 32'd0);
          check("stall_quot_frozen", 32'(dif.quot), 32'(q_hold));
        end
        dif.en = 1'b1;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      if (dif.ready) break;
      check("busy_in_run", 32'(dif.busy), 32'd1);
    end

    check("latency", 32'(k), 32'(lat));
    check("ready", 32'(dif.ready), 32'd1);
    check("busy_with_ready", 32'(dif.busy), 32'd1);
    check("quot", 32'(dif.quot), 32'(eq));
    check("rem", 32'(dif.rem), 32'(er));
    check("div_zero", 32'(dif.div_zero), 32'(edz));
    check("ovf", 32'(dif.ovf), 32'(eov));

    // A valid coincident with the ready cycle must not start a new operation.
    dif.valid = scramble;
    @(posedge clk);
    @(negedge clk);
    dif.valid = 1'b0;
    check("ready_one_cycle", 32'(dif.ready), 32'd0);
    check("busy_drops", 32'(dif.busy), 32'd0);
    check("quot_hold", 32'(dif.quot), 32'(eq));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          p, ne, sel, st;
    logic [15:0] a, b;

    rst_n         = 1'b0;
    dif.en        = 1'b0;
    dif.valid     = 1'b0;
    dif.precision = '0;
    dif.jia       = '0;
    dif.yi        = '0;
    #3;
    check("reset_busy", 32'(dif.busy), 32'd0);
    check("reset_ready", 32'(dif.ready), 32'd0);
    check("reset_quot", 32'(dif.quot), 32'd0);
    check("reset_rem", 32'(dif.rem), 32'd0);
    check("reset_div_zero", 32'(dif.div_zero), 32'd0);
    check("reset_ovf", 32'(dif.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8, 16'd100, 16'd7, 0, 1'b0);
    do_op(8, 16'hFF9C, 16'd7, 0, 1'b0);
    do_op(8, 16'd100, 16'hFFF9, 0, 1'b0);
    do_op(16, 16'd1234, 16'd0, 0, 1'b0);
    do_op(16, 16'd30000, 16'd3, 3, 1'b0);
    do_op(16, 16'd1000, 16'd7, 0, 1'b1);
    do_op(16, 16'h8000, 16'hFFFF, 0, 1'b0);
    do_op(4, 16'hFFF8, 16'hFFFF, 0, 1'b0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    dif.en        = 1'b1;
    dif.valid     = 1'b1;
    dif.precision = 6'd16;
    dif.jia       = 16'd30000;
    dif.yi        = 16'd3;
    @(posedge clk);
    @(negedge clk);
    dif.valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(dif.busy), 32'd0);
    check("midrun_rst_ready", 32'(dif.ready), 32'd0);
    check("midrun_rst_quot", 32'(dif.quot), 32'd0);
    check("midrun_rst_rem", 32'(dif.rem), 32'd0);
    check("midrun_rst_ovf", 32'(dif.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 16'd7, 16'd2, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      p   = $urandom_range(0, 20);
      ne  = (p == 0 || p > 16) ? 16 : p;
      a   = 16'($urandom);
      b   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        b = 16'($urandom) << ne;
      end else if (sel == 1) begin
        a = (16'($urandom) << ne) | (16'd1 << (ne - 1));
        b = (16'($urandom) << ne) | 16'((32'd1 << ne) - 1);
      end else if (sel == 2) begin
        b = 16'($urandom_range(1, 5));
      end
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      do_op(p, a, b, st, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
